poop_dispatcher: RTL and testbench
==================================

// Module: poop_dispatcher
// PURPOSE
//  Producer side of the poop deploy interface. Turns the player's fire button into
//  one-cycle per-slot deploy pulses and held initial coordinates for the poop slot array.
//  Round-robin allocates free slots, tracks each slot's lifetime in frames and enforces
//  a frame-based fire cooldown. Sits between the bird/player logic and the poop renderer.
// PARAMETERS
//  NUM_OF_POOPS     8    number of poop slots (>=2); width of deploy/busy vectors
//  LIFETIME_FRAMES  120  frames a slot stays busy after deploy (fall + splash), >=1
//  COOLDOWN_FRAMES  15   frames after a deploy during which new fire presses are dropped
// PORTS
//  clk                  in   1              system clock
//  resetN               in   1              async reset, active low
//  startOfFrame         in   1              one-cycle pulse per video frame
//  fire                 in   1              fire button level, synchronous to clk
//  birdCoordinates      in   [1:0][10:0]    signed bird top-left; [0]=X, [1]=Y
//  deploy_poop          out  [N-1:0]        one-hot, one-cycle deploy pulse per slot
//  initial_coordinates  out  [N-1:0][1:0][10:0]  signed launch coords per slot, held
//  poopsBusy            out  [N-1:0]        slot occupied (lifetime counter nonzero)
//  fireAccepted         out  1              one-cycle pulse in the deploy cycle
//  fireDropped          out  1              one-cycle pulse when a press is rejected
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr_ptr=0, cooldown=0, all life counters=0,
//   fire_d=0. Async assert; deassert takes effect on the next clk edge.
//  Edge detect: fire_d <= fire each cycle; press = fire & ~fire_d. Holding fire high
//   produces exactly one press.
//  FSM (all outputs registered):
//   IDLE:    press & cooldown==0 -> latch birdCoordinates into coord_l, go SEARCH.
//            press & cooldown!=0 -> fireDropped=1 for one cycle, stay IDLE.
//   SEARCH:  scan slots rr_ptr, rr_ptr+1, ... (mod N); first with poopsBusy=0 -> sel.
//            found -> DEPLOY; none free -> fireDropped pulse, go IDLE. One cycle.
//   DEPLOY:  deploy_poop[sel]=1, fireAccepted=1 (this cycle only);
//            initial_coordinates[sel]<=coord_l; life[sel]<=LIFETIME_FRAMES;
//            rr_ptr<=(sel+1) mod N; cooldown<=COOLDOWN_FRAMES; go IDLE.
//  Latency: press sampled at edge k -> deploy_poop/fireAccepted high for the cycle after
//   edge k+2 (exactly one cycle). Presses seen in SEARCH/DEPLOY -> fireDropped pulse.
//  Frame counters: on startOfFrame, each nonzero life[i] decrements, cooldown decrements
//   if nonzero; both saturate at 0. poopsBusy[i] = (life[i]!=0), registered with life.
//  Simultaneous: DEPLOY coincident with startOfFrame -> life[sel] and cooldown load full
//   values (load beats decrement); other slots still decrement. Slot whose life reaches 0
//   on the same edge SEARCH samples is still busy for that scan (uses pre-edge value).
//  initial_coordinates[i] change only in DEPLOY for i; unchanged while slot busy/idle.
//  Widths: life counter $clog2(LIFETIME_FRAMES+1), cooldown $clog2(COOLDOWN_FRAMES+1),
//   rr_ptr $clog2(N); wrap rr_ptr N-1 -> 0. Coordinates passed unmodified (no offset).
//  COOLDOWN_FRAMES=0: every press reaching IDLE proceeds to SEARCH.
//  Reset mid-operation: any pending DEPLOY is abandoned; no deploy pulse emitted.
// TESTING
//  1. Reset, bird=(100,50), single press -> deploy_poop=8'h01 one cycle 3 edges later,
//     initial_coordinates[0]=(100,50), fireAccepted=1, poopsBusy=8'h01.
//  2. Hold fire high 50 cycles -> exactly one deploy, no fireDropped.
//  3. Press again 5 frames after #1 (cooldown 15) -> fireDropped pulse, no deploy;
//     press at frame 16 -> deploy_poop=8'h02 (round-robin advanced).
//  4. Fill all 8 slots (COOLDOWN_FRAMES=0), 9th press -> fireDropped, deploy_poop=0;
//     after 120 frames slot 0 frees -> next press deploys slot 0.
//  5. DEPLOY coincident with startOfFrame -> life[sel]=120, cooldown=15, others -1.
//  6. Assert resetN low during SEARCH -> no deploy pulse; all outputs 0, rr_ptr=0.

Source files
------------

// File: rtl/poop_dispatcher.sv
// Converts fire-button presses into per-slot deploy pulses with launch coordinates,
// allocating slots round-robin and tracking slot lifetime and fire cooldown in frames.
module poop_dispatcher #(
   parameter int unsigned NUM_OF_POOPS    = 8,
   parameter int unsigned LIFETIME_FRAMES = 120,
   parameter int unsigned COOLDOWN_FRAMES = 15
) (
   input  logic                                  clk,
   input  logic                                  resetN,
   input  logic                                  startOfFrame,
   input  logic                                  fire,
   input  logic [1:0][10:0]                      birdCoordinates,
   output logic [NUM_OF_POOPS-1:0]               deploy_poop,
   output logic [NUM_OF_POOPS-1:0][1:0][10:0]    initial_coordinates,
   output logic [NUM_OF_POOPS-1:0]               poopsBusy,
   output logic                                  fireAccepted,
   output logic                                  fireDropped
);

   localparam int unsigned N      = NUM_OF_POOPS;
   localparam int unsigned PTR_W  = $clog2(N);
   localparam int unsigned IDX_W  = PTR_W + 1;
   localparam int unsigned LIFE_W = $clog2(LIFETIME_FRAMES + 1);
   localparam int unsigned COOL_W = (COOLDOWN_FRAMES == 0) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

   typedef enum logic [1:0] {IDLE, SEARCH, DEPLOY} state_t;

   state_t                    state, state_nxt;
   logic                      fire_d;
   logic                      press_c;
   logic [PTR_W-1:0]          rr_ptr, rr_nxt;
   logic [PTR_W-1:0]          sel, sel_nxt;
   logic [PTR_W-1:0]          cand_c;
   logic                      found_c;
   logic [IDX_W-1:0]          idx_c;
   logic [1:0][10:0]          coord_l, coord_nxt;
   logic [COOL_W-1:0]         cooldown, cool_nxt;
   logic [LIFE_W-1:0]         life     [N];
   logic [LIFE_W-1:0]         life_nxt [N];
   logic [N-1:0]              deploy_nxt, busy_nxt;
   logic                      acc_nxt, drop_nxt;
   logic [N-1:0][1:0][10:0]   coords_nxt;

   assign press_c = fire & ~fire_d;

   // First free slot starting at rr_ptr, using the registered (pre-edge) busy flags
   always_comb begin
      found_c = 1'b0;
      cand_c  = '0;
      idx_c   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         idx_c = {1'b0, rr_ptr} + IDX_W'(i);
         if (idx_c >= IDX_W'(N)) idx_c = idx_c - IDX_W'(N);
         if (!found_c && !poopsBusy[idx_c[PTR_W-1:0]]) begin
            found_c = 1'b1;
            cand_c  = idx_c[PTR_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next state, registered-output values and frame counter updates
   always_comb begin
      state_nxt  = state;
      sel_nxt    = sel;
      rr_nxt     = rr_ptr;
      coord_nxt  = coord_l;
      deploy_nxt = '0;
      acc_nxt    = 1'b0;
      drop_nxt   = 1'b0;
      coords_nxt = initial_coordinates;
      cool_nxt   = (startOfFrame && cooldown != '0) ? cooldown - COOL_W'(1) : cooldown;
      for (int unsigned i = 0; i < N; i++) begin
         life_nxt[i] = (startOfFrame && life[i] != '0) ? life[i] - LIFE_W'(1) : life[i];
      end

      case (state)
         IDLE: begin
            if (press_c) begin
               if (cooldown == '0) begin
                  coord_nxt = birdCoordinates;
                  state_nxt = SEARCH;
               end else begin
                  drop_nxt = 1'b1;
               end
            end
         end
         SEARCH: begin
            drop_nxt = press_c;
            if (found_c) begin
               sel_nxt   = cand_c;
               state_nxt = DEPLOY;
            end else begin
               drop_nxt  = 1'b1;
               state_nxt = IDLE;
            end
         end
         DEPLOY: begin
            drop_nxt        = press_c;
            deploy_nxt[sel] = 1'b1;
            acc_nxt         = 1'b1;
            coords_nxt[sel] = coord_l;
            life_nxt[sel]   = LIFE_W'(LIFETIME_FRAMES);
            cool_nxt        = COOL_W'(COOLDOWN_FRAMES);
            rr_nxt          = (sel == PTR_W'(N - 1)) ? '0 : sel + PTR_W'(1);
            state_nxt       = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      for (int unsigned i = 0; i < N; i++) begin
         busy_nxt[i] = (life_nxt[i] != '0);
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         fire_d              <= 1'b0;
         rr_ptr              <= '0;
         sel                 <= '0;
         coord_l             <= '0;
         cooldown            <= '0;
         deploy_poop         <= '0;
         fireAccepted        <= 1'b0;
         fireDropped         <= 1'b0;
         initial_coordinates <= '0;
         poopsBusy           <= '0;
         for (int unsigned i = 0; i < N; i++) life[i] <= '0;
      end else begin
         fire_d              <= fire;
         rr_ptr              <= rr_nxt;
         sel                 <= sel_nxt;
         coord_l             <= coord_nxt;
         cooldown            <= cool_nxt;
         deploy_poop         <= deploy_nxt;
         fireAccepted        <= acc_nxt;
         fireDropped         <= drop_nxt;
         initial_coordinates <= coords_nxt;
         poopsBusy           <= busy_nxt;
         for (int unsigned i = 0; i < N; i++) life[i] <= life_nxt[i];
      end
   end

endmodule

// File: tb/tb_poop_dispatcher.sv
// Directed bench for poop_dispatcher: instance a uses default parameters,
// instance b has no cooldown; both share stimulus.
module tb_poop_dispatcher;

   localparam int unsigned N = 8;

   logic                   clk = 1'b0;
   logic                   resetN, sof, fire;
   logic [1:0][10:0]       bird;
   logic [N-1:0]           a_dep, a_busy, b_dep, b_busy;
   logic [N-1:0][1:0][10:0] a_coords, b_coords;
   logic                   a_acc, a_drop, b_acc, b_drop;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   poop_dispatcher #(.NUM_OF_POOPS(8), .LIFETIME_FRAMES(120), .COOLDOWN_FRAMES(15)) dut_a (
      .clk(clk), .resetN(resetN), .startOfFrame(sof), .fire(fire), .birdCoordinates(bird),
      .deploy_poop(a_dep), .initial_coordinates(a_coords), .poopsBusy(a_busy),
      .fireAccepted(a_acc), .fireDropped(a_drop));

   poop_dispatcher #(.NUM_OF_POOPS(8), .LIFETIME_FRAMES(120), .COOLDOWN_FRAMES(0)) dut_b (
      .clk(clk), .resetN(resetN), .startOfFrame(sof), .fire(fire), .birdCoordinates(bird),
      .deploy_poop(b_dep), .initial_coordinates(b_coords), .poopsBusy(b_busy),
      .fireAccepted(b_acc), .fireDropped(b_drop));

   typedef struct {
      logic       fire;
      logic       sof;
      logic [7:0] dep;
      logic       acc;
      logic       drop;
      logic [7:0] busy;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic f, input logic s, input logic [7:0] d,
                               input logic a, input logic dr, input logic [7:0] b);
      vec_t v;
      v.fire = f; v.sof = s; v.dep = d; v.acc = a; v.drop = dr; v.busy = b;
      tbl.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetN = 1'b0;
      fire   = 1'b0;
      sof    = 1'b0;
      step();
      step();
      resetN = 1'b1;
      step();
   endtask

   task automatic frames(input int n);
      repeat (n) begin
         sof = 1'b1;
         step();
         sof = 1'b0;
         step();
      end
   endtask

   // Single press: fire high for a few cycles, then low; collects every pulse seen
   task automatic press(output logic [7:0] da, output logic dra,
                        output logic [7:0] db, output logic drb);
      da = '0; dra = 1'b0; db = '0; drb = 1'b0;
      fire = 1'b1;
      repeat (4) begin
         step();
         da |= a_dep; dra |= a_drop; db |= b_dep; drb |= b_drop;
      end
      fire = 1'b0;
      repeat (3) begin
         step();
         da |= a_dep; dra |= a_drop; db |= b_dep; drb |= b_drop;
      end
   endtask

   logic [7:0] da, db;
   logic       dra, drb;
   int         n_dep, n_drop;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      resetN = 1'b0;
      fire   = 1'b0;
      sof    = 1'b0;
      bird[0] = 11'd100;
      bird[1] = 11'd50;

      // Single press, hold-off by cooldown, round-robin advance
      add(1, 0, 8'h00, 0, 0, 8'h00);
      add(1, 0, 8'h00, 0, 0, 8'h00);
      add(1, 0, 8'h01, 1, 0, 8'h01);
      add(0, 0, 8'h00, 0, 0, 8'h01);
      for (int i = 0; i < 5; i++) begin
         add(0, 1, 8'h00, 0, 0, 8'h01);
         add(0, 0, 8'h00, 0, 0, 8'h01);
      end
      add(1, 0, 8'h00, 0, 1, 8'h01);
      add(0, 0, 8'h00, 0, 0, 8'h01);
      for (int i = 0; i < 11; i++) begin
         add(0, 1, 8'h00, 0, 0, 8'h01);
         add(0, 0, 8'h00, 0, 0, 8'h01);
      end
      add(1, 0, 8'h00, 0, 0, 8'h01);
      add(1, 0, 8'h00, 0, 0, 8'h01);
      add(1, 0, 8'h02, 1, 0, 8'h03);
      add(0, 0, 8'h00, 0, 0, 8'h03);

      do_reset();
      chk("reset_a_dep",    64'(a_dep),  64'h0);
      chk("reset_a_busy",   64'(a_busy), 64'h0);
      chk("reset_a_acc",    64'(a_acc),  64'h0);
      chk("reset_a_drop",   64'(a_drop), 64'h0);
      chk("reset_a_coords", 64'(a_coords == '0), 64'h1);
      chk("reset_b_flags",  64'({b_dep, b_busy, b_acc, b_drop}), 64'h0);
      chk("reset_b_coords", 64'(b_coords == '0), 64'h1);

      for (int i = 0; i < tbl.size(); i++) begin
         fire = tbl[i].fire;
         sof  = tbl[i].sof;
         step();
         chk($sformatf("vec%0d_dep", i),  64'(a_dep),  64'(tbl[i].dep));
         chk($sformatf("vec%0d_acc", i),  64'(a_acc),  64'(tbl[i].acc));
         chk($sformatf("vec%0d_drop", i), 64'(a_drop), 64'(tbl[i].drop));
         chk($sformatf("vec%0d_busy", i), 64'(a_busy), 64'(tbl[i].busy));
      end
      fire = 1'b0;
      sof  = 1'b0;
      chk("coords_slot0", 64'(a_coords[0]), 64'({11'd50, 11'd100}));
      chk("coords_slot1", 64'(a_coords[1]), 64'({11'd50, 11'd100}));

      // Held fire yields exactly one deploy
      do_reset();
      n_dep = 0;
      n_drop = 0;
      fire = 1'b1;
      repeat (50) begin
         step();
         if (a_dep != '0) n_dep++;
         if (a_drop) n_drop++;
      end
      fire = 1'b0;
      repeat (3) begin
         step();
         if (a_dep != '0) n_dep++;
         if (a_drop) n_drop++;
      end
      chk("hold_deploys", 64'(n_dep),  64'd1);
      chk("hold_drops",   64'(n_drop), 64'd0);

      // No cooldown: fill all slots, overflow press, lifetime expiry
      do_reset();
      for (int i = 0; i < 8; i++) begin
         press(da, dra, db, drb);
         chk($sformatf("fill%0d_dep", i),  64'(db),  64'(8'h01 << i));
         chk($sformatf("fill%0d_drop", i), 64'(drb), 64'h0);
      end
      press(da, dra, db, drb);
      chk("full_dep",  64'(db),     64'h0);
      chk("full_drop", 64'(drb),    64'h1);
      chk("full_busy", 64'(b_busy), 64'hFF);
      frames(119);
      chk("life119_busy", 64'(b_busy), 64'hFF);
      frames(1);
      chk("life120_busy", 64'(b_busy), 64'h00);
      press(da, dra, db, drb);
      chk("refill_dep", 64'(db), 64'h01);

      // Deploy coinciding with a frame pulse: full loads win, other slot still counts
      bird[0] = 11'd100;
      bird[1] = 11'd50;
      do_reset();
      press(da, dra, db, drb);
      chk("sim_first_dep", 64'(da), 64'h01);
      frames(15);
      bird[0] = 11'h7FB;
      bird[1] = 11'd300;
      fire = 1'b1;
      step();
      step();
      sof = 1'b1;
      step();
      chk("sim_dep", 64'(a_dep), 64'h02);
      chk("sim_acc", 64'(a_acc), 64'h1);
      sof  = 1'b0;
      fire = 1'b0;
      step();
      chk("sim_coords1", 64'(a_coords[1]), 64'({11'd300, 11'h7FB}));
      chk("sim_coords0", 64'(a_coords[0]), 64'({11'd50, 11'd100}));
      frames(14);
      press(da, dra, db, drb);
      chk("cool14_dep",  64'(da),  64'h0);
      chk("cool14_drop", 64'(dra), 64'h1);
      frames(1);
      press(da, dra, db, drb);
      chk("cool15_dep",  64'(da),  64'h04);
      chk("cool15_drop", 64'(dra), 64'h0);
      frames(88);
      chk("slot0_f103", 64'(a_busy[0]), 64'h1);
      frames(1);
      chk("slot0_f104", 64'(a_busy[0]), 64'h0);
      chk("slot1_f104", 64'(a_busy[1]), 64'h1);
      frames(15);
      chk("slot1_f119", 64'(a_busy[1]), 64'h1);
      frames(1);
      chk("slot1_f120", 64'(a_busy), 64'h04);

      // Reset while searching abandons the deploy and clears the pointer
      do_reset();
      press(da, dra, db, drb);
      chk("rst_pre_dep", 64'(da), 64'h01);
      frames(15);
      fire = 1'b1;
      step();
      resetN = 1'b0;
      #1;
      chk("rst_async_busy",   64'(a_busy), 64'h0);
      chk("rst_async_coords", 64'(a_coords == '0), 64'h1);
      fire = 1'b0;
      n_dep = 0;
      repeat (3) begin
         step();
         if (a_dep != '0 || a_acc) n_dep++;
      end
      resetN = 1'b1;
      step();
      step();
      if (a_dep != '0 || a_acc) n_dep++;
      chk("rst_no_deploy", 64'(n_dep), 64'd0);
      chk("rst_outputs",   64'({a_dep, a_busy, a_acc, a_drop}), 64'h0);
      press(da, dra, db, drb);
      chk("rst_rr_dep", 64'(da), 64'h01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
